disp_write_arbiter: RTL and testbench

//  Shares the 16-bit write-only port of the DOGM240 display block between two requesters:
//  the CPU display-memory writer (port A) and the annunciator/status writer (port B).

---
 rtl/disp_write_arbiter_pkg.sv | 21 ++
 rtl/disp_write_arbiter_rr_arb2.sv | 20 ++
 rtl/disp_write_arbiter.sv | 126 ++++++++++++
 tb/tb_disp_write_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_write_arbiter_pkg.sv
// Shared widths, state and grant encodings for the display write arbiter.
package disp_write_arbiter_pkg;

    localparam int unsigned DISP_ADDR_W = 10;
    localparam int unsigned DISP_DATA_W = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_e;

    typedef enum logic {
        GntA = 1'b0,
        GntB = 1'b1
    } grant_e;

    // One-hot request/grant vector position for each port.
    localparam int unsigned PORT_A = 0;
    localparam int unsigned PORT_B = 1;

endpackage

// File: rtl/disp_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time is granted.
module disp_write_arbiter_rr_arb2
    import disp_write_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_grant_i == GntA) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/disp_write_arbiter.sv
// Shares the display write port between two requesters and runs a whole-RAM clear sequence.
module disp_write_arbiter
    import disp_write_arbiter_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DISP_ADDR_W,
    parameter int unsigned       DATA_W    = DISP_DATA_W,
    parameter int unsigned       CLR_WORDS = 1024,
    parameter logic [DATA_W-1:0] CLR_DATA  = '0
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              a_req_in,
    input  logic [ADDR_W-1:0] a_addr_in,
    input  logic [DATA_W-1:0] a_data_in,
    output logic              a_ack_o,
    input  logic              b_req_in,
    input  logic [ADDR_W-1:0] b_addr_in,
    input  logic [DATA_W-1:0] b_data_in,
    output logic              b_ack_o,
    input  logic              clr_start_in,
    output logic              clr_busy_o,
    output logic [ADDR_W-1:0] disp_addr_o,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_we_o
);

    localparam int unsigned   CntW    = ADDR_W + 1;
    localparam logic [CntW-1:0] ClrLast = CntW'(CLR_WORDS - 1);

    state_e            state_q;
    grant_e            last_grant_q;
    logic [CntW-1:0]   cnt_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              busy_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic [1:0] elig;
    logic [1:0] gnt;

    // A port is not re-granted in the cycle its previous write is acknowledged.
    always_comb begin
        elig         = 2'b00;
        elig[PORT_A] = a_req_in & ~a_ack_q;
        elig[PORT_B] = b_req_in & ~b_ack_q;
    end

    disp_write_arbiter_rr_arb2 u_arb (
        .req_i        (elig),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= StIdle;
            last_grant_q <= GntB;
            cnt_q        <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            we_q    <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (clr_start_in) begin
                        // First clear word is issued directly from the start pulse.
                        busy_q <= 1'b1;
                        we_q   <= 1'b1;
                        addr_q <= '0;
                        data_q <= CLR_DATA;
                        if (ClrLast == '0) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q   <= CntW'(1);
                            state_q <= StClear;
                        end
                    end else if (gnt[PORT_A]) begin
                        we_q         <= 1'b1;
                        addr_q       <= a_addr_in;
                        data_q       <= a_data_in;
                        a_ack_q      <= 1'b1;
                        last_grant_q <= GntA;
                    end else if (gnt[PORT_B]) begin
                        we_q         <= 1'b1;
                        addr_q       <= b_addr_in;
                        data_q       <= b_data_in;
                        b_ack_q      <= 1'b1;
                        last_grant_q <= GntB;
                    end
                end
                StClear: begin
                    busy_q <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= cnt_q[ADDR_W-1:0];
                    data_q <= CLR_DATA;
                    // Leaving here while the last word registers lets arbitration run during
                    // the final busy cycle, so a waiting write lands right as busy drops.
                    if (cnt_q == ClrLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_ack_o     = a_ack_q;
    assign b_ack_o     = b_ack_q;
    assign clr_busy_o  = busy_q;
    assign disp_we_o   = we_q;
    assign disp_addr_o = addr_q;
    assign disp_data_o = data_q;

endmodule

// File: tb/tb_disp_write_arbiter.sv
// Scoreboard bench for disp_write_arbiter: stimulus queues expected writes, a monitor checks them.
module tb_disp_write_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NW = 1024;

    typedef logic [AW+DW+1:0] item_t;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic          a_req_in = 1'b0;
    logic [AW-1:0] a_addr_in = '0;
    logic [DW-1:0] a_data_in = '0;
    logic          a_ack_o;
    logic          b_req_in = 1'b0;
    logic [AW-1:0] b_addr_in = '0;
    logic [DW-1:0] b_data_in = '0;
    logic          b_ack_o;
    logic          clr_start_in = 1'b0;
    logic          clr_busy_o;
    logic [AW-1:0] disp_addr_o;
    logic [DW-1:0] disp_data_o;
    logic          disp_we_o;

    item_t exp_q[$];
    item_t exp_item;
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    disp_write_arbiter dut (
        .clk_in       (clk),
        .reset_in     (reset_in),
        .a_req_in     (a_req_in),
        .a_addr_in    (a_addr_in),
        .a_data_in    (a_data_in),
        .a_ack_o      (a_ack_o),
        .b_req_in     (b_req_in),
        .b_addr_in    (b_addr_in),
        .b_data_in    (b_data_in),
        .b_ack_o      (b_ack_o),
        .clr_start_in (clr_start_in),
        .clr_busy_o   (clr_busy_o),
        .disp_addr_o  (disp_addr_o),
        .disp_data_o  (disp_data_o),
        .disp_we_o    (disp_we_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic item_t mk(input logic aa, input logic ba, input logic [AW-1:0] ad,
                                 input logic [DW-1:0] d);
        return {aa, ba, ad, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        repeat (4) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!reset_in) begin
                    if (disp_we_o) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_write got addr=%h data=%h want no write",
                                     disp_addr_o, disp_data_o);
                        end else begin
                            exp_item = exp_q.pop_front();
                            check("write", 32'({a_ack_o, b_ack_o, disp_addr_o, disp_data_o}),
                                  32'(exp_item));
                        end
                    end else if (a_ack_o || b_ack_o) begin
                        check("ack_without_we", 32'({a_ack_o, b_ack_o}), 32'd0);
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) tick();
        check("rst_we", 32'(disp_we_o), 32'd0);
        check("rst_busy", 32'(clr_busy_o), 32'd0);
        check("rst_acks", 32'({a_ack_o, b_ack_o}), 32'd0);
        check("rst_addr", 32'(disp_addr_o), 32'd0);
        check("rst_data", 32'(disp_data_o), 32'd0);
        reset_in = 1'b0;
        tick();

        // Single A write held through its ack cycle
        exp_q.push_back(mk(1'b1, 1'b0, 10'h005, 16'hA55A));
        a_addr_in = 10'h005;
        a_data_in = 16'hA55A;
        a_req_in  = 1'b1;
        tick();
        check("a_first_we", 32'(disp_we_o), 32'd1);
        tick();
        a_req_in = 1'b0;
        drain("drain_single_a");

        // Both ports held after reset: A,B,A,B,A,B
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        a_addr_in = 10'h011;
        a_data_in = 16'h1111;
        b_addr_in = 10'h022;
        b_data_in = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(1'b1, 1'b0, 10'h011, 16'h1111));
            exp_q.push_back(mk(1'b0, 1'b1, 10'h022, 16'h2222));
        end
        a_req_in = 1'b1;
        b_req_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("ab_we", 32'(disp_we_o), 32'd1);
        end
        a_req_in = 1'b0;
        b_req_in = 1'b0;
        drain("drain_ab");

        // A held alone: one write every other cycle
        a_addr_in = 10'h123;
        a_data_in = 16'hC3C3;
        repeat (3) exp_q.push_back(mk(1'b1, 1'b0, 10'h123, 16'hC3C3));
        a_req_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("a_alone_we", 32'(disp_we_o), 32'(k % 2));
        end
        a_req_in = 1'b0;
        drain("drain_a_alone");

        // Clear with a B request in the start cycle
        for (int i = 0; i < NW; i++) exp_q.push_back(mk(1'b0, 1'b0, AW'(i), 16'h0000));
        exp_q.push_back(mk(1'b0, 1'b1, 10'h3FF, 16'hBEEF));
        b_addr_in    = 10'h3FF;
        b_data_in    = 16'hBEEF;
        b_req_in     = 1'b1;
        clr_start_in = 1'b1;
        tick();
        clr_start_in = 1'b0;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (clr_busy_o) n++;
                else break;
            end
            check("clr_busy_len", 32'(n), 32'(NW));
            check("b_after_clr_we", 32'({disp_we_o, b_ack_o}), 32'b11);
            check("b_after_clr_addr", 32'(disp_addr_o), 32'h3FF);
        end
        tick();
        b_req_in = 1'b0;
        drain("drain_clr_b");

        // Second start pulse during a clear is ignored
        for (int i = 0; i < NW; i++) exp_q.push_back(mk(1'b0, 1'b0, AW'(i), 16'h0000));
        clr_start_in = 1'b1;
        tick();
        clr_start_in = 1'b0;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (clr_busy_o) n++;
                else break;
                clr_start_in = (c == 100);
            end
            clr_start_in = 1'b0;
            check("clr_restart_busy_len", 32'(n), 32'(NW));
        end
        drain("drain_clr_restart");

        // Reset at clear write 300 aborts the clear
        for (int i = 0; i <= 300; i++) exp_q.push_back(mk(1'b0, 1'b0, AW'(i), 16'h0000));
        clr_start_in = 1'b1;
        tick();
        clr_start_in = 1'b0;
        begin
            logic found;
            found = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (disp_we_o && disp_addr_o == 10'd300) begin
                    found = 1'b1;
                    break;
                end
            end
            check("found_write_300", 32'(found), 32'd1);
        end
        #1;
        reset_in = 1'b1;
        @(negedge clk);
        check("abort_we", 32'(disp_we_o), 32'd0);
        check("abort_busy", 32'(clr_busy_o), 32'd0);
        check("abort_acks", 32'({a_ack_o, b_ack_o}), 32'd0);
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        repeat (20) tick();
        check("abort_no_more_writes", 32'(disp_we_o), 32'd0);
        drain("drain_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
